// File: rtl/ahb_arb_pkg.sv
// ahb_arb_pkg: shared arbiter state encoding, defaults and selection helpers
package ahb_arb_pkg;
  localparam int DEF_NUM_MASTERS = 4;
  localparam int DEF_SEL_W = 2;
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GRANT = 2'b01
  } arb_state_e;
  function automatic logic tr_done(input logic hready, input logic hresp);
    return hready & ~hresp;
  endfunction
  function automatic int rr_pos(input int last, input int i, input int n, input logic rr);
    return rr ? (last + 1 + i) % n : i;
  endfunction
endpackage

// File: rtl/ahb_rr_pick.sv
// ahb_rr_pick: rotating or fixed priority encoder returning the winning requester index
module ahb_rr_pick
  import ahb_arb_pkg::*;
#(
  parameter int N = DEF_NUM_MASTERS,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  input  logic             mode,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);
  logic [IDX_W-1:0] c;
  always_comb begin
    idx = '0;
    valid = 1'b0;
    c = '0;
    for (int i = N - 1; i >= 0; i--) begin
      c = IDX_W'(rr_pos(int'(last), i, N, mode));
      if (req[c]) begin
        idx = c;
        valid = 1'b1;
      end
    end
  end
endmodule

// File: rtl/ahb_param_arbiter.sv
// ahb_param_arbiter: parametrised AHB arbiter with fixed/round-robin selection and hold watchdog
module ahb_param_arbiter
  import ahb_arb_pkg::*;
#(
  parameter int NUM_MASTERS = DEF_NUM_MASTERS,
  parameter int SEL_W = DEF_SEL_W,
  parameter bit RR_MODE = 1'b1,
  parameter int MAX_HOLD = 16,
  parameter int IDX_W = $clog2(NUM_MASTERS)
) (
  input  logic                         hclk,
  input  logic                         hresetn,
  input  logic [NUM_MASTERS-1:0]       hreq,
  input  logic [NUM_MASTERS*SEL_W-1:0] sel_in,
  input  logic                         hready_out,
  input  logic                         hresp,
  output logic [NUM_MASTERS-1:0]       hgrant,
  output logic [SEL_W-1:0]             sel,
  output logic [IDX_W-1:0]             hmaster,
  output logic                         busy,
  output logic                         hold_timeout
);
  localparam int CNT_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  arb_state_e state_q, state_d;
  logic [NUM_MASTERS-1:0] hgrant_q, hgrant_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [IDX_W-1:0] hmaster_q, hmaster_d, last_q, last_d, pick_last, win_idx;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic tout_q, tout_d;
  logic win_valid, done, in_idle, in_grant, wd_hit, do_grant, do_clear;
  ahb_rr_pick #(.N(NUM_MASTERS), .IDX_W(IDX_W)) u_pick (
    .req  (hreq),
    .last (pick_last),
    .mode (RR_MODE),
    .idx  (win_idx),
    .valid(win_valid)
  );
  always_comb begin
    done = tr_done(hready_out, hresp);
    in_idle = state_q == IDLE;
    in_grant = state_q == GRANT;
    pick_last = in_grant ? hmaster_q : last_q;
    wd_hit = (MAX_HOLD > 0) && in_grant && !done && cnt_q == CNT_W'(MAX_HOLD - 1);
    do_grant = win_valid && (in_idle || (in_grant && done));
    do_clear = !do_grant && !in_idle && (!in_grant || done || wd_hit);
    state_d = do_grant ? GRANT : do_clear ? IDLE : state_q;
    hgrant_d = do_grant ? NUM_MASTERS'(1) << win_idx : do_clear ? '0 : hgrant_q;
    sel_d = do_grant ? sel_in[win_idx*SEL_W +: SEL_W] : do_clear ? '0 : sel_q;
    hmaster_d = do_grant ? win_idx : hmaster_q;
    last_d = (in_grant && (done || wd_hit)) ? hmaster_q : last_q;
    cnt_d = do_grant ? '0 : (in_grant && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
    tout_d = wd_hit;
  end
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q <= IDLE;
      hgrant_q <= '0;
      sel_q <= '0;
      hmaster_q <= '0;
      last_q <= IDX_W'(NUM_MASTERS - 1);
      cnt_q <= '0;
      tout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hgrant_q <= hgrant_d;
      sel_q <= sel_d;
      hmaster_q <= hmaster_d;
      last_q <= last_d;
      cnt_q <= cnt_d;
      tout_q <= tout_d;
    end
  end
  assign hgrant = hgrant_q;
  assign sel = sel_q;
  assign hmaster = hmaster_q;
  assign busy = |hgrant_q;
  assign hold_timeout = tout_q;
endmodule

// File: doc/ahb_param_arbiter.md
Name: ahb_param_arbiter

Overview:
- Parametrised AHB bus arbiter: NUM_MASTERS requesters, fixed-priority or round-robin selection.
- Grant is held until the slave reports a completed transfer (hready_out=1, hresp=0).
- Hands off directly to the next requester without an idle cycle, and enforces a hold-time watchdog.
- Sits between the master ports and the address/write-data muxes; drives the one-hot grant and the registered slave-select code.

Parameters:
- NUM_MASTERS, 4, number of requesting masters (2..16).
- SEL_W, 2, width of each master's slave-select code.
- RR_MODE, 1, 0 = fixed priority (index 0 highest); 1 = round-robin.
- MAX_HOLD, 16, max cycles a grant may be held without tr_done; 0 disables the watchdog.
- IDX_W, $clog2(NUM_MASTERS), width of the master index (derived; not overridden).

Ports:
- hclk  in  1  bus clock
- hresetn  in  1  asynchronous active-low reset
- hreq  in  NUM_MASTERS  per-master bus request
- sel_in  in  NUM_MASTERS*SEL_W  master i's select code in bits [i*SEL_W +: SEL_W]
- hready_out  in  1  ready from selected slave
- hresp  in  1  error response from selected slave (1 = error)
- hgrant  out  NUM_MASTERS  one-hot grant, registered
- sel  out  SEL_W  slave-select code of granted master, registered
- hmaster  out  IDX_W  index of granted master, registered
- busy  out  1  1 while any grant is active
- hold_timeout  out  1  one-cycle pulse when the watchdog revokes a grant

Behaviour:
- Reset (async, hresetn=0):
  - state=IDLE; hgrant=0; sel=0; hmaster=0; busy=0; hold_timeout=0.
  - RR pointer last=NUM_MASTERS-1, so master 0 is first in search order.
  - Hold counter=0.
  - Reset asserted mid-grant drops the grant immediately.
- Definitions:
  - tr_done = hready_out & ~hresp.
  - Arbitration winner:
    - RR_MODE=0: lowest index with hreq=1.
    - RR_MODE=1: first index with hreq=1 searching last+1, last+2, … modulo NUM_MASTERS.
- State IDLE:
  - No hreq set: stay IDLE, outputs 0.
  - Any hreq set at edge k: GRANT; at edge k+1 hgrant[w]=1, hmaster=w, sel=sel_in[w], busy=1, counter=0.
  - Latency is one cycle from request to grant.
- State GRANT:
  - sel is latched at grant and held; later sel_in changes are ignored until the next arbitration.
  - Grant persists while tr_done=0, even if the granted hreq drops.
  - hresp=1 is not completion; the grant is held.
  - On tr_done:
    - last=hmaster.
    - Re-arbitrate the same cycle, excluding nothing: with RR the current owner ranks last, so it may regain the bus only if it is the sole requester.
    - Winner exists: the new grant appears at the next edge, with no IDLE gap.
    - No requester: IDLE, outputs cleared next edge.
  - Watchdog (MAX_HOLD>0):
    - Counter increments each GRANT cycle without tr_done.
    - When counter==MAX_HOLD-1 and tr_done=0: hold_timeout=1 for one cycle, last=hmaster, go IDLE, outputs cleared.
    - tr_done in the same cycle takes precedence; no timeout.
    - Counter saturates and is cleared on every new grant.
- Invariants:
  - hgrant is always zero or one-hot.
  - busy == |hgrant.
  - hmaster is valid only when busy=1; it holds its last value otherwise.
- Out-of-range: unknown state returns to IDLE.

Decomposition:
- Shared package ahb_arb_pkg:
  - state encoding IDLE/GRANT.
  - tr_done helper function.
  - default NUM_MASTERS/SEL_W constants.
- Sub-module ahb_rr_pick:
  - Combinational rotate-priority-encoder.
  - Inputs: req vector, last index, mode.
  - Outputs: winner index, valid.
  - Reusable by other bus arbiters.

Test Plan:
- Reset then hreq=4'b0110, RR_MODE=1 -> one cycle later hgrant=4'b0010, hmaster=1, busy=1; after tr_done hgrant=4'b0100 with no idle cycle.
- RR_MODE=0, hreq=4'b1111 held, tr_done every 3rd cycle -> master 0 is always re-granted; RR_MODE=1 same stimulus -> grant order 0,1,2,3,0.
- Granted master 2 with sel_in[2]=2'b11, then sel_in[2] changes to 2'b01 mid-grant -> sel stays 2'b11 until tr_done.
- hresp=1, hready_out=1 for 5 cycles with MAX_HOLD=16 -> grant held; then hready_out=1, hresp=0 -> grant released.
- MAX_HOLD=4, hready_out=0 forever -> hold_timeout pulses once 4 cycles after grant, hgrant=0 next edge; pending hreq re-granted in round-robin order.
- hresetn low during an active grant to master 3 -> hgrant=0, sel=0, busy=0 immediately (asynchronously); after release, master 0 wins first.
